// File: rtl/seq_mul_acc_pkg.sv
// rtl/seq_mul_acc_pkg.sv - shared constants and state encoding for seq_mul_acc
//
// Contents:
//   state_t       FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   DEF_WIDTH     default operand width
//   DEF_CNT_W     iteration counter width for DEF_WIDTH
//   cnt_width()   iteration counter width for any operand width
package seq_mul_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_acc_if.sv
// rtl/seq_mul_acc_if.sv - start/busy/done operand and result bundle for seq_mul_acc
//
// Signals:
//   start        request, sampled only while the unit is idle
//   Q, B, rem    multiplier, multiplicand, addend (unsigned, WIDTH bits)
//   busy         high while iterating
//   done         one-cycle completion pulse
//   Res          result Q*B + rem (2*WIDTH bits), held until next completion
//   err          pair-check flag, meaningful only while done is high
// Modports: master drives operands and start; slave is the arithmetic unit.
interface seq_mul_acc_if
  import seq_mul_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH-1:0]     B;
  logic [WIDTH-1:0]     rem;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Res;
  logic                 err;

  modport master (
    output start, Q, B, rem,
    input  busy, done, Res, err
  );

  modport slave (
    input  start, Q, B, rem,
    output busy, done, Res, err
  );

endinterface

// File: rtl/seq_mul_acc.sv
// rtl/seq_mul_acc.sv - shift-and-add unit computing Res = Q*B + rem, one multiplier bit per clock
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   bus    seq_mul_acc_if.slave: start/Q/B/rem in, busy/done/Res/err out
// Build option:
//   SEQ_MUL_ACC_CHECK_EN  when defined, err flags operand triples a restoring
//                         divider cannot produce (B == 0 or rem >= B); when
//                         undefined, err is tied to 0 and no comparator exists.
module seq_mul_acc
  import seq_mul_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  seq_mul_acc_if.slave     bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state_q, state_d;

  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   res_q;

  logic [2*WIDTH-1:0]   acc_sum;
  logic                 last_iter;
  logic                 busy_c;
  logic                 done_c;

  // The result cannot exceed 2^(2W) - 2^W, so the plain 2W-bit add never
  // needs a carry-out.
  always_comb begin
    acc_sum   = acc_q;
    last_iter = 1'b0;
    if (mplier_q[0]) begin
      acc_sum = acc_q + mcand_q;
    end
    if (state_q == ST_RUN && cnt_q == CW'(WIDTH - 1)) begin
      last_iter = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // busy and done decode the registered state only, so no input reaches an
  // output combinationally.
  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c = 1'b1;
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            mcand_q  <= {{WIDTH{1'b0}}, bus.B};
            mplier_q <= bus.Q;
            acc_q    <= {{WIDTH{1'b0}}, bus.rem};
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_iter) begin
            res_q <= acc_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.Res  = res_q;

`ifdef SEQ_MUL_ACC_CHECK_EN
  // Captured with the operands, so later changes on B/rem cannot disturb it.
  logic flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else if (state_q == ST_IDLE && bus.start) begin
      flag_q <= (bus.B == '0) || (bus.rem >= bus.B);
    end
  end

  assign bus.err = done_c & flag_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mul_acc.sv
// tb/tb_seq_mul_acc.sv - scoreboard bench for seq_mul_acc
module tb_seq_mul_acc;
  import seq_mul_acc_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] res;
    logic           err;
    int             at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_mul_acc_if #(.WIDTH(W)) bus ();

  seq_mul_acc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ncnt     = 0;
  exp_t sb[$];

  task automatic check(input string nm, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (negedge %0d)", nm, act, req, ncnt);
    end
  endtask

  function automatic logic exp_err(input logic [W-1:0] b, input logic [W-1:0] r);
`ifdef SEQ_MUL_ACC_CHECK_EN
    return (b == 0) || (r >= b);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: counts negedges, pops the scoreboard on every done pulse.
  initial begin : mon
    logic prev_done;
    int   busy_len;
    int   last_busy;
    exp_t e;
    prev_done = 1'b0;
    busy_len  = 0;
    last_busy = 0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (bus.busy) begin
        busy_len++;
      end else begin
        if (busy_len != 0) last_busy = busy_len;
        busy_len = 0;
      end
      if (bus.done) begin
        if (prev_done) begin
          check("done_width", prev_done, 0);
        end else if (sb.size() == 0) begin
          check("unexpected_done", bus.done, 0);
        end else begin
          e = sb.pop_front();
          check("res", bus.Res, e.res);
          check("err", bus.err, e.err);
          check("latency", ncnt, e.at);
          check("busy_len", last_busy, W);
        end
      end else if (prev_done) begin
        check("err_clear", bus.err, 0);
      end
      prev_done = bus.done;
    end
  end

  // Start applied just after negedge n; its done must appear at negedge n+9.
  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic [2*W-1:0] res);
    exp_t e;
    @(negedge clk); #1;
    bus.Q = q; bus.B = b; bus.rem = r; bus.start = 1'b1;
    e.res = res; e.err = exp_err(b, r); e.at = ncnt + W + 1;
    sb.push_back(e);
    @(negedge clk); #1;
    bus.start = 1'b0;
    bus.Q = ~q; bus.B = b + 8'd3; bus.rem = r ^ 8'h5a;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : drv
    exp_t e;
    int   n;
    rst = 1'b1;
    bus.start = 1'b0; bus.Q = '0; bus.B = '0; bus.rem = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_res",  bus.Res,  0);
    check("rst_err",  bus.err,  0);
    rst = 1'b0;

    issue(8'd13, 8'd5, 8'd3, 16'd68);
    drain();
    issue(8'd255, 8'd255, 8'd254, 16'd65279);
    drain();
    issue(8'd0, 8'd200, 8'd17, 16'd17);
    drain();
    issue(8'd9, 8'd0, 8'd0, 16'd0);
    drain();
    issue(8'd2, 8'd5, 8'd7, 16'd17);
    drain();

    // start pulsed mid-RUN must be ignored
    issue(8'd13, 8'd5, 8'd3, 16'd68);
    repeat (2) @(negedge clk);
    #1;
    bus.Q = 8'd255; bus.B = 8'd255; bus.rem = 8'd255; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    drain();

    // start held high: accepts every W+2 cycles
    @(negedge clk); #1;
    bus.Q = 8'd3; bus.B = 8'd4; bus.rem = 8'd1; bus.start = 1'b1;
    n = ncnt;
    for (int i = 0; i < 3; i++) begin
      e.res = 16'd13; e.err = exp_err(8'd4, 8'd1); e.at = n + W + 1 + i * (W + 2);
      sb.push_back(e);
    end
    repeat (2 * (W + 2) + 1) @(negedge clk);
    #1;
    bus.start = 1'b0;
    drain();

    // reset on the 4th RUN edge aborts without a done pulse
    @(negedge clk); #1;
    bus.Q = 8'd13; bus.B = 8'd5; bus.rem = 8'd3; bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_res",  bus.Res,  0);
    check("abort_err",  bus.err,  0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    issue(8'd13, 8'd5, 8'd3, 16'd68);
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
